// File: rtl/vector_loop_sequencer_if.sv
// Tuple issue bus between the loop sequencer and decode/execute: valid/ready handshake plus tuple.
// wr_wom is the combinational fire of the handshake.
interface vector_loop_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              issue_valid;
    logic              issue_ready;
    logic              wr_wom;
    logic [31:0]       i;
    logic [31:0]       j;
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] wom_addr;

    modport master (
        output issue_valid, wr_wom, i, j, n, wom_addr,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, wr_wom, i, j, n, wom_addr,
        output issue_ready
    );
endinterface

// File: rtl/vector_loop_sequencer.sv
// Walks a height x width tile, issuing one (i, j, n, wom_addr) tuple per handshake, then drains and pulses done.
// Latency: first tuple valid 1 cycle after start; done DRAIN+1 cycles after the last fire.
// Backpressure: tuple and issue_valid hold while issue_ready is low; at most one tuple per cycle.
module vector_loop_sequencer #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32,
    parameter int DRAIN  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DIM_W-1:0]       width,
    input  logic [DIM_W-1:0]       height,
    input  logic [ADDR_W-1:0]      base_addr,
    vector_loop_sequencer_if.master iss,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [DIM_W-1:0]  w_lat;
    logic [DIM_W-1:0]  h_lat;
    logic [DIM_W-1:0]  i_cnt;
    logic [DIM_W-1:0]  j_cnt;
    logic [ADDR_W-1:0] n_cnt;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        drain_cnt;
    logic              vld;
    logic              fire;
    logic              row_end;
    logic              last;

    // All loop-bound comparisons use the latched tile size, never the live inputs.
    assign fire    = vld & iss.issue_ready;
    assign row_end = (j_cnt == w_lat - DIM_W'(1));
    assign last    = row_end && (i_cnt == h_lat - DIM_W'(1));

    assign iss.issue_valid = vld;
    assign iss.wr_wom      = fire;
    assign iss.i           = 32'(i_cnt);
    assign iss.j           = 32'(j_cnt);
    assign iss.n           = n_cnt;
    assign iss.wom_addr    = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            vld       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_lat     <= '0;
            h_lat     <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            n_cnt     <= '0;
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                // Cancel leaves the counters where they were; only the control state drops.
                state <= S_IDLE;
                vld   <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            w_lat <= width;
                            h_lat <= height;
                            busy  <= 1'b1;
                            if (width == '0 || height == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_ISSUE;
                                vld   <= 1'b1;
                                i_cnt <= '0;
                                j_cnt <= '0;
                                n_cnt <= '0;
                                addr  <= base_addr;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (fire) begin
                            if (last) begin
                                vld       <= 1'b0;
                                drain_cnt <= 4'(DRAIN);
                                state     <= S_DRAIN;
                            end else begin
                                j_cnt <= row_end ? '0 : j_cnt + DIM_W'(1);
                                if (row_end) begin
                                    i_cnt <= i_cnt + DIM_W'(1);
                                end
                                n_cnt <= n_cnt + ADDR_W'(1);
                                addr  <= addr + ADDR_W'(4);
                            end
                        end
                    end
                    S_DRAIN: begin
                        drain_cnt <= drain_cnt - 4'd1;
                        if (drain_cnt == 4'd1) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_loop_sequencer.sv
// Bench for vector_loop_sequencer: tuple-queue reference model compared every cycle,
// directed tiles with literal expectations, then randomized tiles, backpressure and aborts.
module tb_vector_loop_sequencer;

    localparam int DRAIN = 3;

    typedef struct {
        logic [31:0] i;
        logic [31:0] j;
        logic [31:0] n;
        logic [31:0] a;
    } tup_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;

    vector_loop_sequencer_if #(.ADDR_W(32)) iss ();

    vector_loop_sequencer #(.DIM_W(16), .ADDR_W(32), .DRAIN(DRAIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .width     (width),
        .height    (height),
        .base_addr (base_addr),
        .iss       (iss),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: the whole tile as a queue of expected tuples, plus the cycle done is due.
    tup_t q[$];
    tup_t m_last;
    tup_t m_e;
    logic m_busy    = 1'b0;
    logic m_ev;
    int   m_done_at = -1;

    tup_t fire_log[$];
    int   fire_cyc[$];
    int   done_log[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_tile(input logic [15:0] w, input logic [15:0] h, input logic [31:0] b);
        tup_t t;
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                t.i = 32'(r);
                t.j = 32'(c);
                t.n = 32'(r * int'(w) + c);
                t.a = b + (t.n << 2);
                q.push_back(t);
            end
        end
    endtask

    always @(negedge clk) begin
        tup_t t;
        if (!rst) begin
            q.delete();
            m_busy    = 1'b0;
            m_done_at = -1;
            m_last    = '{default: '0};
        end
        m_e  = (q.size() > 0) ? q[0] : m_last;
        m_ev = m_busy && (q.size() > 0);
        chk("issue_valid", iss.issue_valid, m_ev);
        chk("wr_wom", iss.wr_wom, m_ev & iss.issue_ready);
        chk("busy", busy, m_busy);
        chk("done", done, (cyc == m_done_at));
        chk("i", iss.i, m_e.i);
        chk("j", iss.j, m_e.j);
        chk("n", iss.n, m_e.n);
        chk("wom_addr", iss.wom_addr, m_e.a);

        if (iss.wr_wom) begin
            t.i = iss.i; t.j = iss.j; t.n = iss.n; t.a = iss.wom_addr;
            fire_log.push_back(t);
            fire_cyc.push_back(cyc);
        end
        if (done) done_log.push_back(cyc);

        if (rst) begin
            if (m_busy && abort) begin
                if (q.size() > 0) m_last = q[0];
                q.delete();
                m_busy    = 1'b0;
                m_done_at = -1;
            end else if (m_busy) begin
                if (m_ev && iss.issue_ready) begin
                    m_last = q.pop_front();
                    if (q.size() == 0) m_done_at = cyc + DRAIN + 1;
                end
                if (cyc == m_done_at) begin
                    m_busy    = 1'b0;
                    m_done_at = -1;
                end
            end else if (start && !abort) begin
                m_busy = 1'b1;
                if (width == 16'd0 || height == 16'd0) m_done_at = cyc + 1;
                else build_tile(width, height, base_addr);
            end
        end
        cyc++;
    end

    task automatic clear_logs();
        fire_log.delete();
        fire_cyc.delete();
        done_log.delete();
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_log.size() == 0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_within_budget", done_log.size() > 0, 1'b1);
        tick();
        tick();
    endtask

    task automatic launch(input logic [15:0] w, input logic [15:0] h, input logic [31:0] b);
        width     = w;
        height    = h;
        base_addr = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    int          s;
    int          k;
    logic [31:0] t1i [6] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
    logic [31:0] t1j [6] = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
    logic [31:0] t1a [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
    logic [31:0] t6a [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        width = '0; height = '0; base_addr = '0;
        iss.issue_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Basic 3x2 tile
        clear_logs();
        launch(16'd3, 16'd2, 32'h100);
        wait_done(40);
        chk("t1_fire_count", fire_log.size(), 6);
        if (fire_log.size() == 6) begin
            for (int m = 0; m < 6; m++) begin
                chk("t1_i", fire_log[m].i, t1i[m]);
                chk("t1_j", fire_log[m].j, t1j[m]);
                chk("t1_n", fire_log[m].n, 32'(m));
                chk("t1_addr", fire_log[m].a, t1a[m]);
            end
            chk("t1_back_to_back", fire_cyc[5] - fire_cyc[0], 5);
            chk("t1_done_latency", done_log[0] - fire_cyc[5], 4);
        end

        // Backpressure at tuple (0,2) for 5 cycles
        clear_logs();
        launch(16'd3, 16'd2, 32'h100);
        tick();
        tick();
        iss.issue_ready = 1'b0;
        repeat (5) tick();
        iss.issue_ready = 1'b1;
        wait_done(40);
        chk("t2_fire_count", fire_log.size(), 6);
        if (fire_log.size() == 6) begin
            chk("t2_stall_gap", fire_cyc[2] - fire_cyc[1], 6);
            chk("t2_held_addr", fire_log[2].a, 32'h108);
        end

        // Degenerate sizes
        clear_logs();
        s = cyc;
        launch(16'd0, 16'd4, 32'h500);
        wait_done(10);
        chk("t3a_fires", fire_log.size(), 0);
        if (done_log.size() > 0) chk("t3a_done_cycle", done_log[0] - s, 1);
        clear_logs();
        s = cyc;
        launch(16'd5, 16'd0, 32'h500);
        wait_done(10);
        chk("t3b_fires", fire_log.size(), 0);
        if (done_log.size() > 0) chk("t3b_done_cycle", done_log[0] - s, 1);

        // Abort after two fires of a 4x4 tile
        clear_logs();
        launch(16'd4, 16'd4, 32'h40);
        k = 0;
        while (fire_log.size() < 2 && k < 20) begin
            tick();
            k++;
        end
        chk("t4_reached_two_fires", fire_log.size() >= 2, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_valid", iss.issue_valid, 1'b0);
        chk("t4_abort_busy", busy, 1'b0);
        repeat (8) tick();
        chk("t4_no_done", done_log.size(), 0);

        // Fresh start, then a start pulse mid-tile that must be ignored
        clear_logs();
        launch(16'd4, 16'd4, 32'h2000);
        tick();
        chk("t4_restart_seen", fire_log.size() > 0, 1'b1);
        if (fire_log.size() > 0) begin
            chk("t4_restart_i", fire_log[0].i, 32'd0);
            chk("t4_restart_n", fire_log[0].n, 32'd0);
            chk("t4_restart_addr", fire_log[0].a, 32'h2000);
        end
        tick();
        launch(16'd1, 16'd1, 32'h9000);
        wait_done(100);
        chk("t4_fire_count", fire_log.size(), 16);
        if (fire_log.size() == 16) begin
            chk("t4_last_n", fire_log[15].n, 32'd15);
            chk("t4_last_addr", fire_log[15].a, 32'h203C);
        end

        // Asynchronous reset between edges during ISSUE
        clear_logs();
        iss.issue_ready = 1'b1;
        launch(16'd4, 16'd4, 32'h300);
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        chk("t5_valid", iss.issue_valid, 1'b0);
        chk("t5_wr_wom", iss.wr_wom, 1'b0);
        chk("t5_i", iss.i, 32'd0);
        chk("t5_j", iss.j, 32'd0);
        chk("t5_n", iss.n, 32'd0);
        chk("t5_addr", iss.wom_addr, 32'd0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("t5_idle_after_release", busy, 1'b0);

        // Address wrap
        clear_logs();
        launch(16'd4, 16'd1, 32'hFFFF_FFF8);
        wait_done(40);
        chk("t6_fire_count", fire_log.size(), 4);
        if (fire_log.size() == 4) begin
            for (int m = 0; m < 4; m++) begin
                chk("t6_addr", fire_log[m].a, t6a[m]);
                chk("t6_n", fire_log[m].n, 32'(m));
            end
        end

        // Randomized tiles, backpressure, aborts and live input changes
        for (int c = 0; c < 1500; c++) begin
            iss.issue_ready = ($urandom_range(0, 3) != 0);
            start           = ($urandom_range(0, 7) == 0);
            abort           = ($urandom_range(0, 60) == 0);
            width           = 16'($urandom_range(0, 5));
            height          = 16'($urandom_range(0, 5));
            base_addr       = $urandom;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        iss.issue_ready = 1'b1;
        repeat (60) tick();
        chk("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_loop_sequencer.md
Name: vector_loop_sequencer

Overview:
- Sequences the vector CPU's image-processing datapath over a height x width pixel tile.
- Issues one (i, j, n, wom_addr) tuple per accepted handshake to the decode/execute stage.
- After the last tuple, drains the pipeline for a fixed number of cycles, then signals completion.
- Sits beside the IF/ID stage. It replaces free-running loop counters with a start/done controlled sequencer.

Parameters:
DIM_W, 16, width of tile dimension inputs and of i/j counters
ADDR_W, 32, width of base address, n and wom_addr
DRAIN, 3, cycles waited after last accepted tuple before done (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin a tile; sampled only in IDLE
abort  input  1  synchronous cancel; highest priority after reset
width  input  DIM_W  columns per row, latched on start
height  input  DIM_W  rows, latched on start
base_addr  input  ADDR_W  write-only-memory base, latched on start
issue_ready  input  1  downstream accepts current tuple
issue_valid  output  1  tuple on i/j/n/wom_addr is valid
i  output  32  current row index, zero-extended
j  output  32  current column index, zero-extended
n  output  ADDR_W  linear index i*width+j, maintained incrementally (no multiplier)
wom_addr  output  ADDR_W  base_addr + 4*n, modulo 2^ADDR_W
wr_wom  output  1  issue_valid & issue_ready (combinational fire)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (rst=0, async) puts the FSM in IDLE. All registered outputs read 0: issue_valid, i, j, n, wom_addr, busy, done. The drain counter is also 0. wr_wom is therefore 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start=1, latch width, height and base_addr.
  - If width==0 or height==0, go to DONE; no tuple is issued.
  - Otherwise go to ISSUE with i=0, j=0, n=0, wom_addr=base_addr, issue_valid=1.
  - start is ignored in every other state.
- ISSUE:
  - Valid/ready handshake. Tuple and issue_valid hold stable while issue_ready=0.
  - On fire with j<width-1: j+=1, n+=1, wom_addr+=4.
  - On fire with j==width-1 and i<height-1: j=0, i+=1, n+=1, wom_addr+=4.
  - On fire of the last tuple (i==height-1, j==width-1): issue_valid falls next cycle. Drain counter loads DRAIN. Go to DRAIN.
  - One tuple per cycle maximum. Back-to-back fires are legal, giving throughput 1/cycle with ready held high.
- DRAIN:
  - Counter decrements each cycle. When it reaches 1, go to DONE.
  - Total cycles from last fire to done-high = DRAIN+1.
- DONE:
  - done=1 for exactly one cycle, busy=1 during it. Next state IDLE.
  - i, j, n and wom_addr keep their last values until the next start.
- abort=1 in ISSUE, DRAIN or DONE:
  - Next cycle IDLE, issue_valid=0, done not pulsed. Counters keep their values.
  - A fire coincident with abort still counts as wr_wom for that cycle.
  - abort in IDLE has no effect, and takes priority over start.
- Arithmetic:
  - Counter comparisons use the latched width/height, never the live inputs.
  - wom_addr wraps modulo 2^ADDR_W without error.
  - Maximum tile 65535x65535. n must not overflow at ADDR_W=32.
- Changing width/height/base_addr inputs mid-tile has no effect.

Test Plan:
1. Basic tile: width=3, height=2, base_addr=0x100, ready=1, DRAIN=3.
   - Fires in order: (i,j,n,addr)= (0,0,0,0x100) (0,1,1,0x104) (0,2,2,0x108) (1,0,3,0x10C) (1,1,4,0x110) (1,2,5,0x114).
   - wr_wom high 6 consecutive cycles. done pulses 4 cycles after the last fire. busy falls the following cycle.
2. Backpressure: same tile with issue_ready low for 5 cycles at tuple (0,2).
   - Tuple (0,2,2,0x108) held stable with issue_valid=1 and wr_wom=0 throughout the stall.
   - Sequence resumes unchanged; exactly 6 fires total.
3. Degenerate sizes: start with width=0, height=4; then width=5, height=0.
   - Each yields busy for 1 cycle, done pulse in the 2nd cycle after start, zero issue_valid cycles.
4. Abort and ignored start: abort asserted after 2 fires of a 4x4 tile; separately, start re-pulsed mid-tile.
   - Abort: IDLE next cycle, no done, issue_valid=0. A fresh start restarts at (0,0,0,base_addr).
   - Re-pulsed start: ignored, sequence unaffected.
5. Async reset mid-operation: rst low between clock edges during ISSUE.
   - All outputs 0 immediately, without waiting for an edge.
   - After release, FSM stays in IDLE until start.
6. Wrap: base_addr=0xFFFFFFF8, width=4, height=1.
   - Addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004. n=0..3; done pulses normally.
